sigma_delta_adc: RTL and testbench
==================================

// Module: sigma_delta_adc
// PURPOSE
//   First-order sigma-delta ADC: the input-side counterpart of the audio DAC. A 1-bit comparator
//   input (pin vs. RC-integrated ADCfb) is synchronised and fed back. Ones are counted over
//   fixed decimation windows to produce excess-2^(OUT_W-1) PCM samples, in the same format
//   as the DAC input. A hysteresis slicer derives a clean EAR bit for tape loading.
// PARAMETERS
//   DECIM_LOG2  8   window length = 2^DECIM_LOG2 Clk cycles
//   OUT_W       9   sample width; must satisfy OUT_W > DECIM_LOG2
//   HYST        16  slicer half-band around midscale, in sample LSBs
// PORTS
//   Clk           in   1      system clock
//   Reset         in   1      synchronous, active-high reset
//   ADCin         in   1      comparator output, asynchronous to Clk
//   ADCfb         out  1      feedback bit to external RC integrator
//   sample        out  OUT_W  PCM sample, excess 2^(OUT_W-1) (midscale = silence)
//   sample_valid  out  1      one-cycle strobe: new sample/ear_bit/clip this cycle
//   ear_bit       out  1      hysteresis-sliced tape/EAR level
//   clip          out  1      last window was all-0 or all-1 (input overload)
// BEHAVIOUR
//   Reset values: ADCfb=0, sample=2^(OUT_W-1), sample_valid=0, ear_bit=0, clip=0; sync flops,
//     phase counter and ones counter = 0. Reset asserted mid-window discards the partial window.
//   Front end: ADCin -> s1 -> s2 -> ADCfb (three flops). ADCfb is the modulator bit;
//     an ADCin edge reaches ADCfb on the 3rd Clk edge.
//   Phase counter: DECIM_LOG2 bits, free-running 0..2^D-1 and wrapping. Cycle 0 = first cycle
//     with Reset low. ones counter: DECIM_LOG2+1 bits, adds ADCfb every cycle.
//   Window end (phase == 2^D-1, that cycle's ADCfb included), at that edge:
//     cnt = final ones total (0..2^D); ones counter restarts at 0 for the next window
//     (it does not carry cnt).
//     sample <= (cnt == 2^D) ? all-ones : cnt << (OUT_W-D), saturating.
//     clip   <= (cnt == 0) || (cnt == 2^D).
//     ear_bit<= 1 if new sample >= 2^(OUT_W-1)+HYST; 0 if <= 2^(OUT_W-1)-HYST; else holds.
//     sample_valid <= 1 for exactly that next cycle; otherwise 0.
//   Cadence: sample_valid high at cycles 2^D, 2*2^D, ... after reset release. There are no gaps
//     and no backpressure: a consumer must take the sample in the strobe cycle. sample, clip and
//     ear_bit hold their value between strobes.
//   Slicer compares the newly computed sample, not the previous one. Thresholds are inclusive.
//     If HYST=0, ear_bit = (sample >= midscale).
//   Arithmetic is unsigned throughout. The shift is zero-fill. Saturation only occurs at cnt == 2^D.
// TESTING (D=8, OUT_W=9, HYST=16)
//   Reset held 5 cycles, ADCin=1 -> ADCfb=0, sample=256, sample_valid=0, ear_bit=0, clip=0.
//   Release; ADCin=1 constant -> first window cnt=253 gives sample=506, clip=0, ear_bit=1;
//     second window sample=511, clip=1; sample_valid strobes at cycles 256 and 512.
//   ADCin=0 constant -> from 2nd window onward sample=0, clip=1, ear_bit=0.
//   ADCin toggling every Clk -> sample=256, clip=0, ear_bit unchanged from prior value.
//   Hysteresis: windows with cnt 192 -> 384, ear=1; cnt 132 -> 264, ear stays 1;
//     cnt 120 -> 240, ear=0; cnt 130 -> 260, ear stays 0.
//   Reset pulsed at phase 100 -> outputs at reset values next cycle; next strobe exactly 256
//     cycles after release; step ADCin 0->1 -> ADCfb=1 three edges later.

Source files
------------

// File: rtl/sigma_delta_adc.sv
// -----------------------------------------------------------------------------
// sigma_delta_adc
//
// First-order sigma-delta ADC front end and decimator.
//
// The external comparator output ADCin (pin voltage vs. the RC-integrated
// ADCfb) is brought into the Clk domain through two synchroniser flops and a
// third flop that is the modulator bit itself. That bit is driven straight back
// out as ADCfb to close the analogue loop.
//
// The decimator counts ones over fixed windows of 2^DECIM_LOG2 cycles and
// turns each count into an excess-2^(OUT_W-1) PCM sample. This is the same
// format the audio DAC consumes. A hysteresis slicer on the new sample
// produces a clean EAR bit for tape loading.
//
// Parameters
//   DECIM_LOG2  window length is 2^DECIM_LOG2 cycles
//   OUT_W       sample width, must be greater than DECIM_LOG2
//   HYST        slicer half-band around midscale, in sample LSBs
//
// Ports
//   Clk           in   system clock
//   Reset         in   synchronous, active-high reset
//   ADCin         in   comparator output, asynchronous to Clk
//   ADCfb         out  modulator bit, fed back to the external RC integrator
//   sample        out  PCM sample, midscale 2^(OUT_W-1) is silence
//   sample_valid  out  one-cycle strobe when sample/ear_bit/clip update
//   ear_bit       out  hysteresis-sliced tape/EAR level
//   clip          out  last window was all zeros or all ones (overload)
// -----------------------------------------------------------------------------
module sigma_delta_adc #(
  parameter int DECIM_LOG2 = 8,
  parameter int OUT_W      = 9,
  parameter int HYST       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ADCin,
  output logic             ADCfb,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             ear_bit,
  output logic             clip
);

  localparam int D     = DECIM_LOG2;
  localparam int SHIFT = OUT_W - DECIM_LOG2;

  localparam int MID_I = 1 << (OUT_W - 1);
  localparam int HI_I  = MID_I + HYST;
  // Clamp the lower threshold at zero so an oversized HYST cannot wrap it.
  localparam int LO_I  = (HYST > MID_I) ? 0 : (MID_I - HYST);

  localparam logic [OUT_W-1:0] MID   = OUT_W'(MID_I);
  // One extra bit so that HI_I can exceed the sample range without wrapping.
  localparam logic [OUT_W:0]   HI_TH = (OUT_W + 1)'(HI_I);
  localparam logic [OUT_W:0]   LO_TH = (OUT_W + 1)'(LO_I);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // sync_q[0], sync_q[1] : metastability synchroniser for ADCin
  // sync_q[2]            : modulator bit, drives ADCfb
  logic [2:0]       sync_q;

  logic [D-1:0]     phase_q, phase_d;
  logic [D:0]       ones_q,  ones_d;

  logic [OUT_W-1:0] sample_q, sample_d;
  logic             valid_q,  valid_d;
  logic             ear_q,    ear_d;
  logic             clip_q,   clip_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [D:0]       window_cnt;
  logic             window_end;
  logic [OUT_W:0]   sample_ext;

  always_comb begin
    // This cycle's modulator bit is included in the running total. At window
    // end the total is therefore the complete count for the window.
    window_cnt = ones_q + {{D{1'b0}}, sync_q[2]};
    window_end = (phase_q == '1);

    phase_d    = phase_q + 1'b1;
    ones_d     = window_cnt;
    sample_d   = sample_q;
    clip_d     = clip_q;
    ear_d      = ear_q;
    valid_d    = 1'b0;
    sample_ext = {1'b0, sample_q};

    if (window_end) begin
      // The new window starts from zero. The finished count is not carried.
      ones_d  = '0;
      valid_d = 1'b1;

      // Only a full window (count == 2^D) can overflow the shifted value.
      // That case saturates to full scale.
      if (window_cnt[D]) begin
        sample_d = '1;
      end else begin
        sample_d = {window_cnt[D-1:0], {SHIFT{1'b0}}};
      end

      clip_d = (window_cnt == '0) || window_cnt[D];

      // Slice the freshly computed sample. Thresholds are inclusive.
      // The upper test has priority, so HYST = 0 gives ear = (sample >= MID).
      sample_ext = {1'b0, sample_d};
      if (sample_ext >= HI_TH) begin
        ear_d = 1'b1;
      end else if (sample_ext <= LO_TH) begin
        ear_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // A reset asserted mid-window throws away the partial count.
      sync_q   <= '0;
      phase_q  <= '0;
      ones_q   <= '0;
      sample_q <= MID;
      valid_q  <= 1'b0;
      ear_q    <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], ADCin};
      phase_q  <= phase_d;
      ones_q   <= ones_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ear_q    <= ear_d;
      clip_q   <= clip_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ADCfb        = sync_q[2];
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign ear_bit      = ear_q;
  assign clip         = clip_q;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// -----------------------------------------------------------------------------
// tb_sigma_delta_adc
//
// Bench for sigma_delta_adc with DECIM_LOG2=8, OUT_W=9, HYST=16.
//
// Each stimulus cycle also advances a small reference model of the modulator
// delay and window counting. Every window end pushes the expected
// {sample, clip, ear_bit} onto a queue. A negedge monitor pops the queue on
// every sample_valid strobe. The scenario tasks also check the literal values
// for the cases they construct.
// -----------------------------------------------------------------------------
module tb_sigma_delta_adc;

  localparam int D     = 8;
  localparam int OUT_W = 9;
  localparam int HYST  = 16;
  localparam int WIN   = 1 << D;

  logic             Clk   = 1'b0;
  logic             Reset = 1'b1;
  logic             ADCin = 1'b1;
  logic             ADCfb;
  logic [OUT_W-1:0] sample;
  logic             sample_valid;
  logic             ear_bit;
  logic             clip;

  sigma_delta_adc #(
    .DECIM_LOG2(D),
    .OUT_W     (OUT_W),
    .HYST      (HYST)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ADCin       (ADCin),
    .ADCfb       (ADCfb),
    .sample      (sample),
    .sample_valid(sample_valid),
    .ear_bit     (ear_bit),
    .clip        (clip)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [OUT_W-1:0] s;
    logic             c;
    logic             e;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  logic m_s1, m_s2, m_fb, m_ear;
  int   m_phase, m_ones;
  int   cyc;

  // Apply one non-reset cycle with ADCin = a. Return 1 time unit after the edge.
  task automatic step(input logic a);
    int   cnt;
    exp_t e;
    ADCin = a;
    Reset = 1'b0;
    if (m_phase == WIN - 1) begin
      cnt  = m_ones + int'(m_fb);
      e.s  = (cnt == WIN) ? 9'd511 : 9'(cnt * 2);
      e.c  = (cnt == 0) || (cnt == WIN);
      if (int'(e.s) >= 256 + HYST)      m_ear = 1'b1;
      else if (int'(e.s) <= 256 - HYST) m_ear = 1'b0;
      e.e  = m_ear;
      sb_q.push_back(e);
      m_ones = 0;
    end else begin
      m_ones = m_ones + int'(m_fb);
    end
    m_phase = (m_phase + 1) % WIN;
    m_fb = m_s2;
    m_s2 = m_s1;
    m_s1 = a;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // Hold Reset for n edges, then clear the model. Reset is released by the
  // next step() call, so that call's cycle is cycle 0.
  task automatic do_reset(input int n, input logic a);
    Reset = 1'b1;
    ADCin = a;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
    m_s1 = 1'b0; m_s2 = 1'b0; m_fb = 1'b0; m_ear = 1'b0;
    m_phase = 0; m_ones = 0; cyc = 0;
    sb_q.delete();
  endtask

  // Scoreboard monitor: every strobe must match the next expected window.
  exp_t mon_e;
  always @(negedge Clk) begin
    if (sample_valid === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_strobe at cyc %0d: got strobe, want none", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (sample !== mon_e.s || clip !== mon_e.c || ear_bit !== mon_e.e) begin
          n_err++;
          $display("FAIL sb_window at cyc %0d: got s=%0d c=%b e=%b want s=%0d c=%b e=%b",
                   cyc, sample, clip, ear_bit, mon_e.s, mon_e.c, mon_e.e);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset(5, 1'b1);
    n_vec++;
    if (ADCfb !== 1'b0) begin n_err++; $display("FAIL reset_ADCfb got %b want 0", ADCfb); end
    n_vec++;
    if (sample !== 9'd256) begin n_err++; $display("FAIL reset_sample got %0d want 256", sample); end
    n_vec++;
    if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    n_vec++;
    if (ear_bit !== 1'b0) begin n_err++; $display("FAIL reset_ear got %b want 0", ear_bit); end
    n_vec++;
    if (clip !== 1'b0) begin n_err++; $display("FAIL reset_clip got %b want 0", clip); end
  endtask

  task automatic test_const_high();
    for (int i = 1; i <= 2 * WIN; i++) begin
      step(1'b1);
      if (i == WIN - 1 || i == 2 * WIN - 1) begin
        n_vec++;
        if (sample_valid !== 1'b0) begin n_err++; $display("FAIL high_early_strobe cyc %0d got %b want 0", cyc, sample_valid); end
      end
      if (i == WIN) begin
        n_vec++;
        if (sample_valid !== 1'b1 || sample !== 9'd506 || clip !== 1'b0 || ear_bit !== 1'b1) begin
          n_err++;
          $display("FAIL high_win1 got v=%b s=%0d c=%b e=%b want v=1 s=506 c=0 e=1", sample_valid, sample, clip, ear_bit);
        end
      end
      if (i == 2 * WIN) begin
        n_vec++;
        if (sample_valid !== 1'b1 || sample !== 9'd511 || clip !== 1'b1 || ear_bit !== 1'b1) begin
          n_err++;
          $display("FAIL high_win2 got v=%b s=%0d c=%b e=%b want v=1 s=511 c=1 e=1", sample_valid, sample, clip, ear_bit);
        end
      end
    end
  endtask

  task automatic test_const_low();
    for (int i = 1; i <= 2 * WIN; i++) begin
      step(1'b0);
      if (i == WIN) begin
        // Three pipelined ones from the preceding all-high window remain.
        n_vec++;
        if (sample_valid !== 1'b1 || sample !== 9'd6 || clip !== 1'b0 || ear_bit !== 1'b0) begin
          n_err++;
          $display("FAIL low_win1 got v=%b s=%0d c=%b e=%b want v=1 s=6 c=0 e=0", sample_valid, sample, clip, ear_bit);
        end
      end
      if (i == 2 * WIN) begin
        n_vec++;
        if (sample_valid !== 1'b1 || sample !== 9'd0 || clip !== 1'b1 || ear_bit !== 1'b0) begin
          n_err++;
          $display("FAIL low_win2 got v=%b s=%0d c=%b e=%b want v=1 s=0 c=1 e=0", sample_valid, sample, clip, ear_bit);
        end
      end
    end
  endtask

  // Alternating input, starting with 1, after a window whose tail was zeros.
  task automatic test_toggle(input logic exp_ear);
    for (int i = 1; i <= 2 * WIN; i++) begin
      step(logic'(i % 2));
      if (i == WIN) begin
        n_vec++;
        if (sample_valid !== 1'b1 || sample !== 9'd254 || clip !== 1'b0 || ear_bit !== exp_ear) begin
          n_err++;
          $display("FAIL toggle_win1 got v=%b s=%0d c=%b e=%b want v=1 s=254 c=0 e=%b", sample_valid, sample, clip, ear_bit, exp_ear);
        end
      end
      if (i == 2 * WIN) begin
        n_vec++;
        if (sample_valid !== 1'b1 || sample !== 9'd256 || clip !== 1'b0 || ear_bit !== exp_ear) begin
          n_err++;
          $display("FAIL toggle_win2 got v=%b s=%0d c=%b e=%b want v=1 s=256 c=0 e=%b", sample_valid, sample, clip, ear_bit, exp_ear);
        end
      end
    end
  endtask

  task automatic test_hysteresis();
    int   hn[5]   = '{192, 132, 120, 130, 136};
    int   hs[5]   = '{384, 264, 240, 260, 272};
    logic he[5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    // One silent window flushes the toggle pattern out of the sync chain.
    for (int k = 0; k < WIN; k++) step(1'b0);
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < WIN; k++) step(logic'(k < hn[w]));
      n_vec++;
      if (sample_valid !== 1'b1 || int'(sample) != hs[w] || clip !== 1'b0 || ear_bit !== he[w]) begin
        n_err++;
        $display("FAIL hyst_cnt%0d got v=%b s=%0d c=%b e=%b want v=1 s=%0d c=0 e=%b",
                 hn[w], sample_valid, sample, clip, ear_bit, hs[w], he[w]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 100; k++) step(1'b1);
    do_reset(1, 1'b0);
    n_vec++;
    if (ADCfb !== 1'b0 || sample !== 9'd256 || sample_valid !== 1'b0 || ear_bit !== 1'b0 || clip !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs got fb=%b s=%0d v=%b e=%b c=%b want fb=0 s=256 v=0 e=0 c=0",
               ADCfb, sample, sample_valid, ear_bit, clip);
    end
    for (int k = 0; k < 10; k++) step(1'b0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1);
      n_vec++;
      if (ADCfb !== logic'(k == 3)) begin
        n_err++;
        $display("FAIL step_latency edge %0d got ADCfb=%b want %b", k, ADCfb, logic'(k == 3));
      end
    end
    while (cyc < WIN) begin
      step(1'b1);
      if (cyc == WIN - 1) begin
        n_vec++;
        if (sample_valid !== 1'b0) begin n_err++; $display("FAIL midreset_early_strobe got %b want 0", sample_valid); end
      end
    end
    n_vec++;
    if (sample_valid !== 1'b1 || sample !== 9'd486 || clip !== 1'b0 || ear_bit !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_win got v=%b s=%0d c=%b e=%b want v=1 s=486 c=0 e=1", sample_valid, sample, clip, ear_bit);
    end
  endtask

  task automatic test_drain();
    step(1'b1);
    @(negedge Clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_missed_strobes got %0d pending want 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_const_high();
    test_const_low();
    test_toggle(1'b0);
    test_hysteresis();
    test_toggle(1'b1);
    test_reset_mid();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
